sqrt_sched: RTL and testbench

//  Round-robin scheduler sharing one iterative 64-bit square-root datapath among NREQ requesters.

---
 rtl/sqrt_sched_pkg.sv | 15 +
 rtl/sqrt_rr_arb.sv | 37 +++
 rtl/sqrt_sched.sv | 111 +++++++++++
 tb/tb_sqrt_sched.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sqrt_sched_pkg.sv
// Shared types and widths for the sqrt_sched round-robin square-root scheduler.
package sqrt_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int XW   = 64;
  localparam int YW   = 32;
  localparam int CNTW = 32;

endpackage

// File: rtl/sqrt_rr_arb.sv
// Combinational round-robin arbiter: lowest requester at or above ptr wins,
// otherwise the lowest requester overall (wrap-around).
module sqrt_rr_arb
  import sqrt_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  id
);

  logic found;

  always_comb begin
    grant = '0;
    id    = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i] && (IDW'(i) >= ptr)) begin
        grant[i] = 1'b1;
        id       = IDW'(i);
        found    = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i]) begin
        grant[i] = 1'b1;
        id       = IDW'(i);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sqrt_sched.sv
// Shares one iterative 64-bit sqrt datapath among NREQ requesters.
// Optional perf counters built only when SQRT_SCHED_PERF_EN is defined.
//
// state | meaning
// IDLE  | datapath parked, arbitrating, accept one operand
// LOAD  | sq_x valid while datapath held in reset (load cycle)
// RUN   | datapath iterating, wait for sq_rdy
// DONE  | result presented until resp_ready, datapath parked
module sqrt_sched
  import sqrt_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*XW-1:0] req_x,
  output logic [NREQ-1:0]   req_ready,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [IDW-1:0]    resp_id,
  output logic [YW-1:0]     resp_root,
  output logic              sq_reset,
  output logic [XW-1:0]     sq_x,
  input  logic [YW-1:0]     sq_y,
  input  logic              sq_rdy,
  output logic [CNTW-1:0]   perf_ops,
  output logic [CNTW-1:0]   perf_busy
);

  state_t          state, state_nxt;
  logic [IDW-1:0]  rr_ptr, gnt_id, ptr_nxt;
  logic [NREQ-1:0] gnt;
  logic [XW-1:0]   sel_x;
  logic            accept;

  sqrt_rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (gnt),
    .id    (gnt_id)
  );

  // Gate with reset_n so no grant is offered while reset is held.
  assign req_ready  = (state == ST_IDLE && reset_n) ? gnt : '0;
  assign accept     = (state == ST_IDLE) && (|gnt);
  assign resp_valid = (state == ST_DONE);
  assign sq_reset   = (state != ST_RUN);
  assign ptr_nxt    = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;

  always_comb begin
    sel_x = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) sel_x = req_x[i*XW +: XW];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept)     state_nxt = ST_LOAD;
      ST_LOAD:                 state_nxt = ST_RUN;
      ST_RUN:  if (sq_rdy)     state_nxt = ST_DONE;
      ST_DONE: if (resp_ready) state_nxt = ST_IDLE;
      default:                 state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr    <= '0;
      sq_x      <= '0;
      resp_id   <= '0;
      resp_root <= '0;
    end else begin
      if (accept) begin
        sq_x    <= sel_x;
        resp_id <= gnt_id;
        rr_ptr  <= ptr_nxt;
      end
      if (state == ST_RUN && sq_rdy) resp_root <= sq_y;
    end
  end

`ifdef SQRT_SCHED_PERF_EN
  logic [CNTW-1:0] ops_q, busy_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ops_q  <= '0;
      busy_q <= '0;
    end else begin
      if (state == ST_DONE && resp_ready && ops_q != '1) ops_q <= ops_q + 1'b1;
      if (state != ST_IDLE && busy_q != '1)              busy_q <= busy_q + 1'b1;
    end
  end

  assign perf_ops  = ops_q;
  assign perf_busy = busy_q;
`else
  assign perf_ops  = '0;
  assign perf_busy = '0;
`endif

endmodule

// File: tb/tb_sqrt_sched.sv
// Self-checking bench for sqrt_sched with a behavioural bit-serial sqrt datapath
// on the sq_* ports; expected roots and grants come from plain-arithmetic models.
module tb_sqrt_sched;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*64-1:0] req_x;
  logic [NREQ-1:0]   req_ready;
  logic              resp_valid;
  logic              resp_ready;
  logic [IDW-1:0]    resp_id;
  logic [31:0]       resp_root;
  logic              sq_reset;
  logic [63:0]       sq_x;
  logic [31:0]       sq_y;
  logic              sq_rdy;
  logic [31:0]       perf_ops;
  logic [31:0]       perf_busy;

  int nerr = 0;
  int nchk = 0;
  int ptr_m = 0;

  sqrt_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_x      (req_x),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_root  (resp_root),
    .sq_reset   (sq_reset),
    .sq_x       (sq_x),
    .sq_y       (sq_y),
    .sq_rdy     (sq_rdy),
    .perf_ops   (perf_ops),
    .perf_busy  (perf_busy)
  );

  always #5 clk = ~clk;

  // Bit-serial sqrt datapath: reset loads bit index 31, one result bit per cycle.
  logic [31:0] dp_y   = '0;
  int          dp_bit = 31;
  logic        dp_rdy = 1'b0;
  assign sq_y   = dp_y;
  assign sq_rdy = dp_rdy;

  always @(posedge clk) begin
    logic [31:0] t;
    if (sq_reset) begin
      dp_y   <= '0;
      dp_bit <= 31;
      dp_rdy <= 1'b0;
    end else if (!dp_rdy) begin
      t = dp_y | (32'd1 << dp_bit);
      if ({32'd0, t} * {32'd0, t} <= sq_x) dp_y <= t;
      if (dp_bit == 0) dp_rdy <= 1'b1;
      else             dp_bit <= dp_bit - 1;
    end
  end

  function automatic logic [31:0] isqrt(input logic [63:0] x);
    longint unsigned lo, hi, mid;
    lo = 0;
    hi = 64'hFFFF_FFFF;
    while (lo < hi) begin
      mid = lo + (hi - lo + 1) / 2;
      if (mid * mid <= x) lo = mid;
      else                hi = mid - 1;
    end
    return lo[31:0];
  endfunction

  function automatic int pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transaction for the requester the model expects to win.
  task automatic op(input int hold, input bit drop, output int wait_n, output logic [31:0] root_o);
    int          exp_id;
    bit          got;
    int          lat;
    logic [63:0] xv;
    logic [31:0] exp_root;
    exp_id = pick(req_valid, ptr_m);
    got    = 1'b0;
    wait_n = -1;
    root_o = '0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (|(req_valid & req_ready)) begin
        got    = 1'b1;
        wait_n = n;
      end
    end
    check("accept_seen", 64'(got), 64'd1);
    if (!got || exp_id < 0) return;
    check("grant", 64'(req_ready), 64'(4'b0001 << exp_id));
    xv       = req_x[exp_id*64 +: 64];
    exp_root = isqrt(xv);
    ptr_m    = (exp_id + 1) % NREQ;
    @(posedge clk); #1;
    if (drop) req_valid[exp_id] = 1'b0;
    req_x[exp_id*64 +: 64] = {$urandom, $urandom};
    check("sq_x_latched", sq_x, xv);
    lat = 0;
    for (int c = 1; c <= 60 && lat == 0; c++) begin
      @(posedge clk); #1;
      if (c == 10) check("sq_x_held", sq_x, xv);
      if (resp_valid) lat = c;
    end
    check("latency", 64'(lat), 64'd34);
    check("resp_id", 64'(resp_id), 64'(exp_id));
    check("resp_root", 64'(resp_root), 64'(exp_root));
    root_o = resp_root;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("hold_valid", 64'(resp_valid), 64'd1);
      check("hold_root", 64'(resp_root), 64'(exp_root));
      check("hold_id", 64'(resp_id), 64'(exp_id));
      check("hold_req_ready", 64'(req_ready), 64'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("retired", 64'(resp_valid), 64'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    check({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
    check({tag, "_resp_id"}, 64'(resp_id), 64'd0);
    check({tag, "_resp_root"}, 64'(resp_root), 64'd0);
    check({tag, "_sq_x"}, sq_x, 64'd0);
    check({tag, "_sq_reset"}, 64'(sq_reset), 64'd1);
    check({tag, "_perf_ops"}, 64'(perf_ops), 64'd0);
    check({tag, "_perf_busy"}, 64'(perf_busy), 64'd0);
  endtask

  initial begin
    int          wn;
    logic [31:0] r;
    reset_n    = 1'b1;
    req_valid  = '0;
    req_x      = '0;
    resp_ready = 1'b0;
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_reset_vals("rst");
    reset_n = 1'b1;
    ptr_m   = 0;

    // single request, known root and latency
    req_x[63:0] = 64'd213213123244;
    req_valid   = 4'b0001;
    op(0, 1'b1, wn, r);
    check("t1_root_const", 64'(r), 64'd461750);

    // all four valid, fixed operands
    req_x     = {64'd65535, 64'd144, 64'd81, 64'd16};
    req_valid = 4'b1111;
    for (int k = 0; k < 4; k++) op(0, 1'b1, wn, r);

    // move pointer to 2, then only 1 and 3 valid
    req_x[127:64] = {$urandom, $urandom};
    req_valid     = 4'b0010;
    op(0, 1'b1, wn, r);
    check("t3_ptr_model", 64'(pick(4'b1010, ptr_m)), 64'd3);
    req_x[255:192] = {$urandom, $urandom};
    req_valid      = 4'b1010;
    op(0, 1'b1, wn, r);
    op(0, 1'b1, wn, r);

    // stall in DONE with a pending request, then one-bubble re-accept
    req_valid = 4'b0011;
    op(10, 1'b1, wn, r);
    op(0, 1'b1, wn, r);
    check("t4_bubble", 64'(wn), 64'd0);

    // async reset during RUN
    req_x[191:128] = {$urandom, $urandom};
    req_valid      = 4'b0100;
    for (int n = 0; n < 40 && !(|req_ready); n++) @(negedge clk);
    @(posedge clk); #1;
    req_valid = 4'b1000;
    req_x[255:192] = 64'hFFFF_FFFF_FFFF_FFFF;
    repeat (10) @(posedge clk);
    #3 reset_n = 1'b0;
    #1 check_reset_vals("t5_async");
    @(posedge clk); #1;
    check_reset_vals("t5_held");
    reset_n = 1'b1;
    ptr_m   = 0;
    op(0, 1'b1, wn, r);
    check("t5_root_max", 64'(r), 64'hFFFF_FFFF);

    // randomized requests and operands
    for (int k = 0; k < 8; k++) begin
      req_x     = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      req_valid = 4'($urandom_range(1, 15));
      op($urandom_range(0, 3), 1'b1, wn, r);
    end
    req_valid = '0;

    // perf counters over three back-to-back ops
    @(posedge clk); #1 reset_n = 1'b0;
    #2 reset_n = 1'b1;
    ptr_m = 0;
    req_x[63:0] = {$urandom, $urandom};
    req_valid   = 4'b0001;
    op(0, 1'b0, wn, r);
    op(0, 1'b0, wn, r);
    check("t6_back_to_back", 64'(wn), 64'd0);
    op(0, 1'b1, wn, r);
`ifdef SQRT_SCHED_PERF_EN
    check("t6_perf_ops", 64'(perf_ops), 64'd3);
    check("t6_perf_busy", 64'(perf_busy), 64'd105);
`else
    check("t6_perf_ops", 64'(perf_ops), 64'd0);
    check("t6_perf_busy", 64'(perf_busy), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", nerr, nchk);
    $fatal(1, "timeout");
  end

endmodule
